stage_fe: RTL and testbench
===========================

# stage_fe

Instruction-fetch stage feeding the decode stage. It holds the PC, issues in-order read requests to instruction memory with a valid/ready request channel and an in-order response channel, and buffers returned words in a small prefetch FIFO. Each cycle it presents one instruction, or a bubble, on `out_inst`/`out_flush` to decode. Decode captures these only when `en && !stall`. The block discards wrong-path fetches when a later stage redirects the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `BUF_DEPTH`, default 2: prefetch FIFO entries and maximum in-flight plus buffered fetches. Must be a power of 2 and ≥1.
- `NOP`, default 32'h0000_0013: instruction word driven while `out_flush`=1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: pipeline enable, shared with decode.
- `stall` in 1: hazard stall, shared with decode. While high, the output register holds.
- `redirect` in 1: PC redirect from execute.
- `redirect_pc` in `DATA_W`: redirect target.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_addr` out `DATA_W`: fetch address, always the current PC.
- `imem_rsp_valid` in 1: response word valid. Responses return in request order.
- `imem_rsp_data` in `INST_W`: response word.
- `out_inst` out `INST_W`: instruction to decode.
- `out_pc` out `DATA_W`: PC of `out_inst`.
- `out_flush` out 1: 1 means bubble; decode treats the slot as invalid.

## Operation
- **State:**
  - `pc`.
  - FIFO of {inst, pc} with `count` entries.
  - `outstanding`: accepted requests not yet answered.
  - `discard`: in-flight responses still to be dropped (discard ≤ outstanding).
  - Output register: `out_inst`, `out_pc`, `out_flush`.
- **Request:**
  - `imem_req_valid` = `!rst && en && !redirect && (outstanding + count < BUF_DEPTH)`.
  - On a fire (valid && ready): `outstanding`+1, `pc` += 4. The add is modulo 2^32, so 0xFFFF_FFFC wraps to 0.
  - While valid && !ready, `imem_addr` stays stable.
- **Response:**
  - `outstanding`−1 on every `imem_rsp_valid`.
  - If `discard`>0, drop the word and decrement `discard`.
  - Otherwise push {data, fetch PC}. The FIFO tracks the PC of each in-flight request with a parallel PC queue or a head-PC counter.
- **Pop (`en && !stall`, no redirect):**
  - FIFO non-empty: load the head into the output register with `out_flush`=0.
  - FIFO empty with an accepted response this cycle: bypass the response straight into the output register.
  - Otherwise load a bubble: `out_flush`=1, `out_inst`=`NOP`, `out_pc` held.
- **Hold:** when `!en || stall`, the output register and FIFO head hold. Responses still push.
- **Redirect (wins over stall and en):**
  - `pc` ← `{redirect_pc[31:2], 2'b00}`.
  - FIFO cleared.
  - `discard` ← `outstanding` − `imem_rsp_valid`; the response arriving this cycle is also dropped.
  - Output register ← bubble.
  - No request fires in the redirect cycle.
- **Reset:**
  - `pc`=`RESET_PC`; `count`, `outstanding`, `discard` = 0.
  - `out_flush`=1, `out_inst`=`NOP`, `out_pc`=0, `imem_req_valid`=0.
  - `imem_rsp_valid` is ignored during `rst`. Instruction memory shares `rst` and drops its in-flight reads.
- **Counter widths:** `$clog2(BUF_DEPTH)+1` bits. They never exceed `BUF_DEPTH` by construction.

## Timing
- **Latency:** with a 1-cycle memory, a request fires in cycle N, the response arrives in N+1, and `out_inst` is valid in N+2 (bypass path).
- **Throughput:** 1 instruction/cycle sustained with `BUF_DEPTH`≥2 and 1-cycle memory.
- **Redirect at cycle R:**
  - `out_flush`=1 at R+1.
  - First request to the target fires at R+1.
  - First target instruction appears at R+3 with 1-cycle memory.
- **Full:** `outstanding + count = BUF_DEPTH` deasserts `imem_req_valid` the same cycle. It reasserts the cycle after a pop or redirect frees a slot.
- **Empty with no arrival:** a pop produces a bubble and never stalls the stage.

## Test plan
- **Reset release, ideal memory (ready=1, 1-cycle rsp), en=1, stall=0:** `imem_addr` = 0,4,8,… on consecutive cycles. `out_flush`=1 for cycles 0–1, then `out_pc` = 0,4,8,… with no gaps.
- **stall=1 for 3 cycles mid-stream:** `out_inst`/`out_pc` hold. `count` reaches 2 and `imem_req_valid`=0. After release, `out_pc` continues +4 with no bubble and no skip.
- **redirect to 0x100 with 2 fetches in flight:** both old responses are dropped. `out_flush`=1 next cycle. Next `imem_addr`=0x100, and the first non-bubble `out_pc`=0x100.
- **redirect_pc=0x103:** `imem_addr`=0x100.
- **imem_req_ready=0 for 4 cycles:** `imem_addr` stays stable and `pc` does not advance. Bubbles appear once the FIFO drains; fetch resumes at the held address.
- **en=0 mid-stream, then rst asserted for 1 cycle with fetches outstanding:** no new requests and outputs hold while en=0. After reset, all outputs are at reset values and the next `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/stage_fe.sv
// stage_fe
// Instruction-fetch stage. Holds the PC, issues in-order fetch requests to
// instruction memory, buffers returned words in a small prefetch FIFO and
// presents one instruction (or a bubble) per cycle to decode.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   en, stall         : pipeline enable / hazard stall shared with decode
//   redirect          : PC redirect from execute, target on redirect_pc
//   imem_req_valid    : fetch request valid, handshake with imem_req_ready
//   imem_addr         : fetch address (always the current PC)
//   imem_rsp_valid    : in-order response strobe with word imem_rsp_data
//   out_inst, out_pc  : instruction word and its PC for decode
//   out_flush         : 1 marks the slot as a bubble (out_inst = NOP)
module stage_fe #(
   parameter int               DATA_W    = 32,
   parameter int               INST_W    = 32,
   parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int               BUF_DEPTH = 2,
   parameter logic [INST_W-1:0] NOP      = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              stall,
   input  logic              redirect,
   input  logic [DATA_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [DATA_W-1:0] imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic [INST_W-1:0] out_inst,
   output logic [DATA_W-1:0] out_pc,
   output logic              out_flush
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [CW:0] DEPTH_V = (CW+1)'(BUF_DEPTH);

   logic [DATA_W-1:0] pc;
   // PC of the next response that will be kept; it only advances on kept
   // responses, so discarded wrong-path words never disturb it.
   logic [DATA_W-1:0] rsp_pc;
   logic [CW-1:0]     count;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     discard;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [INST_W-1:0] fifo_inst [BUF_DEPTH];
   logic [DATA_W-1:0] fifo_pc   [BUF_DEPTH];

   logic [CW:0] occupancy;
   logic        fire;
   logic        rsp_drop;
   logic        rsp_take;
   logic        pop_slot;
   logic        fifo_pop;
   logic        bypass;
   logic        fifo_push;

   // Pointer advance; a single-entry FIFO keeps its pointers pinned at 0.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (BUF_DEPTH == 1) return '0;
      return p + PW'(1);
   endfunction

   // Request and pop decisions. Every accepted request reserves a FIFO slot
   // until its word has left the FIFO, so a push can never overflow it.
   always_comb begin
      occupancy      = {1'b0, outstanding} + {1'b0, count};
      imem_req_valid = !rst && en && !redirect && (occupancy < DEPTH_V);
      imem_addr      = pc;
      fire           = imem_req_valid && imem_req_ready;
      rsp_drop       = (discard != '0);
      rsp_take       = imem_rsp_valid && !rsp_drop;
      pop_slot       = en && !stall && !redirect;
      fifo_pop       = pop_slot && (count != '0);
      bypass         = pop_slot && (count == '0) && rsp_take;
      fifo_push      = rsp_take && !redirect && !bypass;
   end

   // Control state and output register. A redirect overrides en/stall,
   // flushes the FIFO and marks every still-in-flight fetch for discard,
   // including the one answered in the redirect cycle itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         out_inst    <= NOP;
         out_pc      <= '0;
         out_flush   <= 1'b1;
      end else begin
         outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);
         if (rsp_take) rsp_pc <= rsp_pc + DATA_W'(4);
         if (redirect) begin
            pc        <= {redirect_pc[DATA_W-1:2], 2'b00};
            rsp_pc    <= {redirect_pc[DATA_W-1:2], 2'b00};
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            discard   <= outstanding - CW'(imem_rsp_valid);
            out_inst  <= NOP;
            out_flush <= 1'b1;
         end else begin
            if (fire) pc <= pc + DATA_W'(4);
            if (imem_rsp_valid && rsp_drop) discard <= discard - CW'(1);
            if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
            count <= count + CW'(fifo_push) - CW'(fifo_pop);
            if (pop_slot) begin
               if (fifo_pop) begin
                  out_inst  <= fifo_inst[rd_ptr];
                  out_pc    <= fifo_pc[rd_ptr];
                  out_flush <= 1'b0;
                  rd_ptr    <= ptr_inc(rd_ptr);
               end else if (bypass) begin
                  out_inst  <= imem_rsp_data;
                  out_pc    <= rsp_pc;
                  out_flush <= 1'b0;
               end else begin
                  out_inst  <= NOP;
                  out_flush <= 1'b1;
               end
            end
         end
      end
   end

   // Prefetch storage; contents are only meaningful between the pointers,
   // so the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (!rst && fifo_push) begin
         fifo_inst[wr_ptr] <= imem_rsp_data;
         fifo_pc[wr_ptr]   <= rsp_pc;
      end
   end

endmodule

// File: tb/tb_stage_fe.sv
// tb_stage_fe
// Testbench for stage_fe: an in-order instruction memory with configurable
// latency and request backpressure, randomized control inputs, and a
// queue-based reference of the fetch stage compared against the DUT every
// cycle, plus a few fixed-value checks around reset, latency and redirect.
module tb_stage_fe;

   localparam logic [31:0] T_RESET_PC = 32'h0000_0040;
   localparam logic [31:0] T_NOP      = 32'h0000_0013;
   localparam int          T_DEPTH    = 2;

   logic        clk;
   logic        rst;
   logic        en;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_flush;

   stage_fe #(
      .DATA_W(32), .INST_W(32), .RESET_PC(T_RESET_PC),
      .BUF_DEPTH(T_DEPTH), .NOP(T_NOP)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .out_inst(out_inst),
      .out_pc(out_pc), .out_flush(out_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_req_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } slot_t;

   // Memory and reference state
   mem_req_t    memq[$];
   int          last_due;
   int          cycle;
   slot_t       m_fifo[$];
   logic [31:0] m_inflight[$];
   int          m_disc;
   logic [31:0] m_pc;
   logic [31:0] m_out_inst;
   logic [31:0] m_out_pc;
   logic        m_out_flush;

   // Stimulus knobs (percent / per-mille probabilities)
   int k_en_pct, k_stall_pct, k_redir_pct, k_ready_pct, k_rst_pm;
   int k_lat_min, k_lat_max;

   int n_checks;
   int n_errors;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
                  tag, cycle, got, exp);
      end
   endtask

   task automatic resetModel();
      m_fifo.delete();
      m_inflight.delete();
      memq.delete();
      m_disc      = 0;
      m_pc        = T_RESET_PC;
      m_out_inst  = T_NOP;
      m_out_pc    = 32'h0;
      m_out_flush = 1'b1;
      last_due    = cycle;
   endtask

   task automatic applyStimulus(input bit force_rst, input bit force_redir,
                                input logic [31:0] rpc);
      rst            = force_rst || ($urandom_range(0, 999) < k_rst_pm);
      en             = ($urandom_range(0, 99) < k_en_pct);
      stall          = ($urandom_range(0, 99) < k_stall_pct);
      redirect       = force_redir || ($urandom_range(0, 99) < k_redir_pct);
      redirect_pc    = force_redir ? rpc : $urandom;
      imem_req_ready = ($urandom_range(0, 99) < k_ready_pct);
      if (memq.size() > 0 && memq[0].due <= cycle) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memWord(memq[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   // Advance the reference by one clock using the currently driven inputs.
   task automatic modelStep(input bit exp_valid);
      bit          rsp_ok;
      slot_t       rsp;
      mem_req_t    mr;
      int          due;
      rsp_ok = 1'b0;
      if (rst) begin
         resetModel();
         return;
      end
      if (imem_rsp_valid) begin
         mr = memq.pop_front();
         if (m_disc > 0) begin
            m_disc--;
         end else begin
            rsp_ok   = 1'b1;
            rsp.inst = imem_rsp_data;
            rsp.pc   = m_inflight.pop_front();
         end
      end
      if (redirect) begin
         m_disc      = m_disc + m_inflight.size();
         m_inflight.delete();
         m_fifo.delete();
         m_pc        = {redirect_pc[31:2], 2'b00};
         m_out_inst  = T_NOP;
         m_out_flush = 1'b1;
      end else begin
         if (exp_valid && imem_req_ready) begin
            m_inflight.push_back(m_pc);
            due = cycle + $urandom_range(k_lat_min, k_lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: m_pc, due: due});
            m_pc = m_pc + 32'd4;
         end
         if (en && !stall) begin
            if (m_fifo.size() > 0) begin
               slot_t s;
               s           = m_fifo.pop_front();
               m_out_inst  = s.inst;
               m_out_pc    = s.pc;
               m_out_flush = 1'b0;
               if (rsp_ok) m_fifo.push_back(rsp);
            end else if (rsp_ok) begin
               m_out_inst  = rsp.inst;
               m_out_pc    = rsp.pc;
               m_out_flush = 1'b0;
            end else begin
               m_out_inst  = T_NOP;
               m_out_flush = 1'b1;
            end
         end else if (rsp_ok) begin
            m_fifo.push_back(rsp);
         end
      end
   endtask

   task automatic stepCycle(input bit force_rst, input bit force_redir,
                            input logic [31:0] rpc);
      bit exp_valid;
      applyStimulus(force_rst, force_redir, rpc);
      @(negedge clk);
      exp_valid = !rst && en && !redirect &&
                  ((m_disc + m_inflight.size() + m_fifo.size()) < T_DEPTH);
      checkOutput("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_valid});
      checkOutput("imem_addr", imem_addr, m_pc);
      checkOutput("out_inst", out_inst, m_out_inst);
      checkOutput("out_pc", out_pc, m_out_pc);
      checkOutput("out_flush", {31'b0, out_flush}, {31'b0, m_out_flush});
      modelStep(exp_valid);
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic setKnobs(input int e, input int s, input int r,
                           input int rdy, input int lmin, input int lmax,
                           input int rpm);
      k_en_pct    = e;
      k_stall_pct = s;
      k_redir_pct = r;
      k_ready_pct = rdy;
      k_lat_min   = lmin;
      k_lat_max   = lmax;
      k_rst_pm    = rpm;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_flush"}, {31'b0, out_flush}, 32'd1);
      checkOutput({tag, "_inst"}, out_inst, T_NOP);
      checkOutput({tag, "_pc"}, out_pc, 32'h0);
      checkOutput({tag, "_addr"}, imem_addr, T_RESET_PC);
   endtask

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      cycle          = 0;
      rst            = 1'b1;
      en             = 1'b0;
      stall          = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      resetModel();

      // Reset, then ideal memory: first word visible two cycles after fire
      setKnobs(100, 0, 0, 100, 1, 1, 0);
      stepCycle(1'b1, 1'b0, 32'h0);
      checkResetState("rst1");
      stepCycle(1'b0, 1'b0, 32'h0);
      checkOutput("lat_c0_flush", {31'b0, out_flush}, 32'd1);
      checkOutput("lat_c0_addr", imem_addr, T_RESET_PC + 32'd4);
      stepCycle(1'b0, 1'b0, 32'h0);
      checkOutput("lat_c1_flush", {31'b0, out_flush}, 32'd0);
      checkOutput("lat_c1_pc", out_pc, T_RESET_PC);
      checkOutput("lat_c1_inst", out_inst, memWord(T_RESET_PC));
      stepCycle(1'b0, 1'b0, 32'h0);
      checkOutput("lat_c2_pc", out_pc, T_RESET_PC + 32'd4);
      repeat (5) stepCycle(1'b0, 1'b0, 32'h0);

      // Stall three cycles mid-stream
      setKnobs(100, 100, 0, 100, 1, 1, 0);
      repeat (3) stepCycle(1'b0, 1'b0, 32'h0);
      setKnobs(100, 0, 0, 100, 1, 1, 0);
      repeat (4) stepCycle(1'b0, 1'b0, 32'h0);

      // Two fetches in flight, then redirect to 0x100
      setKnobs(100, 0, 0, 100, 2, 2, 0);
      repeat (4) stepCycle(1'b0, 1'b0, 32'h0);
      setKnobs(100, 0, 0, 100, 1, 1, 0);
      stepCycle(1'b0, 1'b1, 32'h0000_0100);
      checkOutput("redir_flush", {31'b0, out_flush}, 32'd1);
      checkOutput("redir_addr", imem_addr, 32'h0000_0100);
      repeat (6) stepCycle(1'b0, 1'b0, 32'h0);

      // Unaligned redirect target
      stepCycle(1'b0, 1'b1, 32'h0000_0103);
      checkOutput("redir_align", imem_addr, 32'h0000_0100);
      repeat (5) stepCycle(1'b0, 1'b0, 32'h0);

      // Memory not ready for four cycles
      setKnobs(100, 0, 0, 0, 1, 1, 0);
      repeat (4) stepCycle(1'b0, 1'b0, 32'h0);
      setKnobs(100, 0, 0, 100, 1, 1, 0);
      repeat (4) stepCycle(1'b0, 1'b0, 32'h0);

      // en low with fetches outstanding, then a one-cycle reset
      setKnobs(100, 0, 0, 100, 2, 2, 0);
      repeat (3) stepCycle(1'b0, 1'b0, 32'h0);
      setKnobs(0, 0, 0, 100, 2, 2, 0);
      repeat (3) stepCycle(1'b0, 1'b0, 32'h0);
      stepCycle(1'b1, 1'b0, 32'h0);
      checkResetState("rst2");
      setKnobs(100, 0, 0, 100, 1, 1, 0);
      repeat (4) stepCycle(1'b0, 1'b0, 32'h0);

      // Randomized traffic
      setKnobs(90, 25, 4, 70, 1, 3, 5);
      repeat (3000) stepCycle(1'b0, 1'b0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
